// File: rtl/dmem_pkg.sv
// ---------------------------------------------------------------------------
// dmem_pkg
// Shared definitions for the data memory responder and its byte array:
//   - size_e   : load/store size encoding (byte, halfword, word, doubleword)
//   - state_e  : responder FSM states (IDLE, WAIT, RESP)
//   - size_bytes() : number of bytes touched by an access of a given size
// ---------------------------------------------------------------------------
package dmem_pkg;

    typedef enum logic [1:0] {
        SIZE_BYTE  = 2'b00,
        SIZE_HALF  = 2'b01,
        SIZE_WORD  = 2'b10,
        SIZE_DWORD = 2'b11
    } size_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_WAIT = 2'b01,
        ST_RESP = 2'b10
    } state_e;

    // Byte count of an access: 1, 2, 4 or 8.
    function automatic logic [3:0] size_bytes(input size_e size);
        logic [3:0] n;
        case (size)
            SIZE_BYTE:  n = 4'd1;
            SIZE_HALF:  n = 4'd2;
            SIZE_WORD:  n = 4'd4;
            SIZE_DWORD: n = 4'd8;
            default:    n = 4'd1;
        endcase
        return n;
    endfunction

endpackage

// File: rtl/dmem_byte_array.sv
// ---------------------------------------------------------------------------
// dmem_byte_array
// Byte-wide storage with one 8-byte combinational read port and one
// byte-enabled synchronous write port. Lane 0 of either port (bits 63:56,
// enable bit 7) maps to the byte at the given address, lane 7 (bits 7:0,
// enable bit 0) to address+7, which gives big-endian ordering when the
// caller uses the most significant lanes for narrower items.
// Storage is deliberately not reset.
//
// Ports:
//   clock    - write clock
//   rd_addr  - byte address of lane 0 of the read window
//   rd_data  - 8 bytes starting at rd_addr, rd_addr byte in bits 63:56
//   wr_en    - write strobe
//   wr_addr  - byte address of lane 0 of the write window
//   wr_data  - 8 write bytes, lane 0 in bits 63:56
//   wr_be    - per-lane byte enables, bit 7 = lane 0
// ---------------------------------------------------------------------------
module dmem_byte_array #(
    parameter int DEPTH_BYTES = 1024,
    parameter int AW          = $clog2(DEPTH_BYTES)
) (
    input  logic          clock,
    input  logic [AW-1:0] rd_addr,
    output logic [63:0]   rd_data,
    input  logic          wr_en,
    input  logic [AW-1:0] wr_addr,
    input  logic [63:0]   wr_data,
    input  logic [7:0]    wr_be
);

    logic [7:0] mem [DEPTH_BYTES];

    // Gather an 8-byte window; indices wrap inside the array, callers never
    // use wrapped lanes because out-of-range accesses are rejected upstream.
    always_comb begin
        rd_data = '0;
        for (int i = 0; i < 8; i++) begin
            rd_data[63-8*i -: 8] = mem[rd_addr + AW'(i)];
        end
    end

    // Write only the enabled lanes.
    always_ff @(posedge clock) begin
        if (wr_en) begin
            for (int i = 0; i < 8; i++) begin
                if (wr_be[7-i]) begin
                    mem[wr_addr + AW'(i)] <= wr_data[63-8*i -: 8];
                end
            end
        end
    end

endmodule

// File: rtl/data_mem_responder.sv
// ---------------------------------------------------------------------------
// data_mem_responder
// Load/store responder for a core data port. A request is accepted in IDLE,
// waits LATENCY cycles in WAIT, then is performed on the edge entering RESP
// and presented until the core takes it. Big-endian byte order; loads are
// zero-extended and right-justified. Out-of-range accesses complete with
// rsp_err=1, rdata=0 and no write.
//
// Optional feature macro: DMEM_ALIGN_CHECK_EN
//   defined   - an address that is not a multiple of the access size gives
//               rsp_err=1 with no access
//   undefined - misaligned accesses are performed byte-wise from addr
//
// Ports:
//   clock, reset      - clock, asynchronous active-high reset
//   req_valid/ready   - request handshake (ready only in IDLE)
//   req_write         - 1 = store, 0 = load
//   req_size          - 00 byte, 01 half, 10 word, 11 dword
//   req_addr          - byte address
//   req_wdata         - store data, right-justified
//   rsp_valid/ready   - response handshake (valid only in RESP)
//   rsp_rdata         - load data (0 for stores and errors)
//   rsp_err           - request failed, no memory side effect
// ---------------------------------------------------------------------------
module data_mem_responder
    import dmem_pkg::*;
#(
    parameter int DEPTH_BYTES = 1024,
    parameter int LATENCY     = 2
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [1:0]  req_size,
    input  logic [31:0] req_addr,
    input  logic [63:0] req_wdata,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [63:0] rsp_rdata,
    output logic        rsp_err
);

    localparam int AW = $clog2(DEPTH_BYTES);
    localparam logic [3:0] WAIT_LOAD = (LATENCY == 0) ? 4'd0 : 4'(LATENCY - 1);

    state_e      state;
    state_e      next_state;
    logic [3:0]  wait_cnt;
    logic        accept;
    logic        enter_resp;

    logic        lat_write;
    size_e       lat_size;
    logic [31:0] lat_addr;
    logic [63:0] lat_wdata;

    logic        acc_write;
    size_e       acc_size;
    logic [31:0] acc_addr;
    logic [63:0] acc_wdata;
    logic        acc_err;
    logic        range_err;
    logic [3:0]  nbytes;
    logic [32:0] end_addr;

    logic [63:0] rd_data;
    logic [63:0] load_data;
    logic [63:0] wr_data;
    logic [7:0]  wr_be;
    logic        wr_en;

    // State register.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state and handshake outputs.
    always_comb begin
        next_state = state;
        req_ready  = 1'b0;
        rsp_valid  = 1'b0;
        case (state)
            ST_IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    next_state = (LATENCY == 0) ? ST_RESP : ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (wait_cnt == 4'd0) begin
                    next_state = ST_RESP;
                end
            end
            ST_RESP: begin
                rsp_valid = 1'b1;
                if (rsp_ready) begin
                    next_state = ST_IDLE;
                end
            end
            default: next_state = ST_IDLE;
        endcase
    end

    assign accept     = req_valid && req_ready;
    assign enter_resp = (next_state == ST_RESP) && (state != ST_RESP);

    // WAIT is entered with LATENCY-1 and left when the count reaches zero,
    // giving exactly LATENCY cycles in WAIT.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wait_cnt <= 4'd0;
        end else if (accept) begin
            wait_cnt <= WAIT_LOAD;
        end else if (state == ST_WAIT && wait_cnt != 4'd0) begin
            wait_cnt <= wait_cnt - 4'd1;
        end
    end

    // Capture the request on acceptance; later changes on the request
    // inputs are ignored until the FSM is back in IDLE.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            lat_write <= 1'b0;
            lat_size  <= SIZE_BYTE;
            lat_addr  <= '0;
            lat_wdata <= '0;
        end else if (accept) begin
            lat_write <= req_write;
            lat_size  <= size_e'(req_size);
            lat_addr  <= req_addr;
            lat_wdata <= req_wdata;
        end
    end

    // The access is performed on the edge entering RESP. With LATENCY=0 that
    // is the acceptance edge itself, so the live request is used in IDLE.
    always_comb begin
        acc_write = lat_write;
        acc_size  = lat_size;
        acc_addr  = lat_addr;
        acc_wdata = lat_wdata;
        if (state == ST_IDLE) begin
            acc_write = req_write;
            acc_size  = size_e'(req_size);
            acc_addr  = req_addr;
            acc_wdata = req_wdata;
        end
    end

    // Range check in 33 bits so addresses near 2^32 cannot wrap into range.
    always_comb begin
        nbytes    = size_bytes(acc_size);
        end_addr  = {1'b0, acc_addr} + {29'b0, nbytes};
        range_err = end_addr > 33'(DEPTH_BYTES);
    end

`ifdef DMEM_ALIGN_CHECK_EN
    logic       misaligned;
    logic [2:0] align_mask;

    // nbytes[2:0]-1 yields 0,1,3,7 for 1,2,4,8 bytes (8 wraps 0 -> 7).
    always_comb begin
        align_mask = nbytes[2:0] - 3'd1;
        misaligned = (acc_addr[2:0] & align_mask) != 3'd0;
        acc_err    = range_err || misaligned;
    end
`else
    always_comb begin
        acc_err = range_err;
    end
`endif

    // Narrow items live in the most significant lanes of the 8-byte window:
    // right-justify on load, left-align and enable the top lanes on store.
    always_comb begin
        load_data = rd_data;
        wr_data   = acc_wdata;
        wr_be     = 8'hFF;
        case (acc_size)
            SIZE_BYTE: begin
                load_data = {56'b0, rd_data[63:56]};
                wr_data   = {acc_wdata[7:0], 56'b0};
                wr_be     = 8'b1000_0000;
            end
            SIZE_HALF: begin
                load_data = {48'b0, rd_data[63:48]};
                wr_data   = {acc_wdata[15:0], 48'b0};
                wr_be     = 8'b1100_0000;
            end
            SIZE_WORD: begin
                load_data = {32'b0, rd_data[63:32]};
                wr_data   = {acc_wdata[31:0], 32'b0};
                wr_be     = 8'b1111_0000;
            end
            SIZE_DWORD: begin
                load_data = rd_data;
                wr_data   = acc_wdata;
                wr_be     = 8'hFF;
            end
            default: begin
                load_data = rd_data;
                wr_data   = acc_wdata;
                wr_be     = 8'hFF;
            end
        endcase
    end

    assign wr_en = enter_resp && acc_write && !acc_err;

    // Response registers only change on the edge entering RESP, so they are
    // stable for the whole time rsp_valid is high.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
        end else if (enter_resp) begin
            rsp_err   <= acc_err;
            rsp_rdata <= (acc_err || acc_write) ? 64'd0 : load_data;
        end
    end

    dmem_byte_array #(
        .DEPTH_BYTES (DEPTH_BYTES),
        .AW          (AW)
    ) u_array (
        .clock   (clock),
        .rd_addr (acc_addr[AW-1:0]),
        .rd_data (rd_data),
        .wr_en   (wr_en),
        .wr_addr (acc_addr[AW-1:0]),
        .wr_data (wr_data),
        .wr_be   (wr_be)
    );

endmodule

// File: tb/tb_data_mem_responder.sv
// ---------------------------------------------------------------------------
// tb_data_mem_responder
// Directed testbench for data_mem_responder (DEPTH_BYTES=1024, LATENCY=2).
// Expected results follow DMEM_ALIGN_CHECK_EN if it is defined for the build.
// ---------------------------------------------------------------------------
module tb_data_mem_responder;

    logic        clock = 1'b0;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [1:0]  req_size;
    logic [31:0] req_addr;
    logic [63:0] req_wdata;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [63:0] rsp_rdata;
    logic        rsp_err;

    int          pass_cnt = 0;
    int          total_cnt = 0;
    logic [63:0] rd;
    logic        er;

    data_mem_responder #(
        .DEPTH_BYTES (1024),
        .LATENCY     (2)
    ) dut (
        .clock     (clock),
        .reset     (reset),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_write (req_write),
        .req_size  (req_size),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_rdata (rsp_rdata),
        .rsp_err   (rsp_err)
    );

    always #5 clock = ~clock;

    // Runs one complete request/response transaction and returns the
    // response fields; a response that never arrives counts as a failure.
    task automatic run_txn(input logic wr, input logic [1:0] sz,
                           input logic [31:0] ad, input logic [63:0] wd,
                           output logic [63:0] rdata, output logic err);
        int cnt;
        @(negedge clock);
        req_valid = 1'b1;
        req_write = wr;
        req_size  = sz;
        req_addr  = ad;
        req_wdata = wd;
        @(posedge clock);
        #1;
        req_valid = 1'b0;
        cnt = 0;
        while (!rsp_valid && cnt < 50) begin
            @(negedge clock);
            cnt++;
        end
        if (!rsp_valid) begin
            total_cnt++;
            $display("[TB] FAIL txn_timeout addr=%h: rsp_valid never rose", ad);
        end
        rdata = rsp_rdata;
        err   = rsp_err;
        @(negedge clock);
        rsp_ready = 1'b1;
        @(posedge clock);
        #1;
        rsp_ready = 1'b0;
    endtask

    task automatic test_reset();
        reset     = 1'b1;
        req_valid = 1'b0;
        req_write = 1'b0;
        req_size  = 2'b00;
        req_addr  = '0;
        req_wdata = '0;
        rsp_ready = 1'b0;
        repeat (3) @(posedge clock);
        @(negedge clock);
        reset = 1'b0;
        #1;
        total_cnt++;
        if (req_ready !== 1'b1) $display("[TB] FAIL reset_req_ready: got %b expected 1", req_ready);
        else pass_cnt++;
        total_cnt++;
        if (rsp_valid !== 1'b0) $display("[TB] FAIL reset_rsp_valid: got %b expected 0", rsp_valid);
        else pass_cnt++;
        total_cnt++;
        if (rsp_rdata !== 64'd0) $display("[TB] FAIL reset_rsp_rdata: got %h expected 0", rsp_rdata);
        else pass_cnt++;
        total_cnt++;
        if (rsp_err !== 1'b0) $display("[TB] FAIL reset_rsp_err: got %b expected 0", rsp_err);
        else pass_cnt++;
    endtask

    task automatic test_endian();
        run_txn(1'b1, 2'b11, 32'h10, 64'h0123_4567_89AB_CDEF, rd, er);
        total_cnt++;
        if (rd !== 64'd0 || er !== 1'b0) $display("[TB] FAIL store_dword: got rdata=%h err=%b expected 0/0", rd, er);
        else pass_cnt++;
        run_txn(1'b0, 2'b00, 32'h10, 64'd0, rd, er);
        total_cnt++;
        if (rd !== 64'h01 || er !== 1'b0) $display("[TB] FAIL load_byte_10: got %h err=%b expected 01/0", rd, er);
        else pass_cnt++;
        run_txn(1'b0, 2'b00, 32'h17, 64'd0, rd, er);
        total_cnt++;
        if (rd !== 64'hEF || er !== 1'b0) $display("[TB] FAIL load_byte_17: got %h err=%b expected ef/0", rd, er);
        else pass_cnt++;
        run_txn(1'b0, 2'b01, 32'h12, 64'd0, rd, er);
        total_cnt++;
        if (rd !== 64'h4567) $display("[TB] FAIL load_half_12: got %h expected 4567", rd);
        else pass_cnt++;
        run_txn(1'b0, 2'b10, 32'h14, 64'd0, rd, er);
        total_cnt++;
        if (rd !== 64'h89AB_CDEF) $display("[TB] FAIL load_word_14: got %h expected 89abcdef", rd);
        else pass_cnt++;
        run_txn(1'b0, 2'b11, 32'h10, 64'd0, rd, er);
        total_cnt++;
        if (rd !== 64'h0123_4567_89AB_CDEF) $display("[TB] FAIL load_dword_10: got %h expected 0123456789abcdef", rd);
        else pass_cnt++;
    endtask

    task automatic test_latency();
        logic [63:0] held;
        @(negedge clock);
        req_valid = 1'b1;
        req_write = 1'b0;
        req_size  = 2'b10;
        req_addr  = 32'h14;
        @(posedge clock);
        #1;
        req_valid = 1'b0;
        total_cnt++;
        if (req_ready !== 1'b0) $display("[TB] FAIL lat_ready_wait: got %b expected 0", req_ready);
        else pass_cnt++;
        @(posedge clock);
        #1;
        total_cnt++;
        if (rsp_valid !== 1'b0) $display("[TB] FAIL lat_valid_edge1: got %b expected 0", rsp_valid);
        else pass_cnt++;
        repeat (2) @(posedge clock);
        #1;
        total_cnt++;
        if (rsp_valid !== 1'b1 || rsp_rdata !== 64'h89AB_CDEF)
            $display("[TB] FAIL lat_valid_edge3: got valid=%b rdata=%h expected 1/89abcdef", rsp_valid, rsp_rdata);
        else pass_cnt++;
        held = rsp_rdata;
        // A different request shows up while the response is stalled.
        req_valid = 1'b1;
        req_write = 1'b1;
        req_size  = 2'b10;
        req_addr  = 32'h14;
        req_wdata = 64'hDEAD_BEEF;
        for (int i = 0; i < 4; i++) begin
            @(posedge clock);
            #1;
            total_cnt++;
            if (rsp_valid !== 1'b1 || req_ready !== 1'b0 || rsp_rdata !== held || rsp_err !== 1'b0)
                $display("[TB] FAIL lat_hold_%0d: got valid=%b ready=%b rdata=%h err=%b expected 1/0/%h/0",
                         i, rsp_valid, req_ready, rsp_rdata, rsp_err, held);
            else pass_cnt++;
        end
        @(negedge clock);
        req_valid = 1'b0;
        rsp_ready = 1'b1;
        @(posedge clock);
        #1;
        rsp_ready = 1'b0;
        total_cnt++;
        if (rsp_valid !== 1'b0 || req_ready !== 1'b1)
            $display("[TB] FAIL lat_release: got valid=%b ready=%b expected 0/1", rsp_valid, req_ready);
        else pass_cnt++;
        run_txn(1'b0, 2'b10, 32'h14, 64'd0, rd, er);
        total_cnt++;
        if (rd !== 64'h89AB_CDEF) $display("[TB] FAIL ignored_req_no_write: got %h expected 89abcdef", rd);
        else pass_cnt++;
    endtask

    task automatic test_range();
        run_txn(1'b1, 2'b01, 32'h3FE, 64'hA55A, rd, er);
        total_cnt++;
        if (er !== 1'b0) $display("[TB] FAIL range_half_store_ok: got err=%b expected 0", er);
        else pass_cnt++;
        run_txn(1'b0, 2'b10, 32'h3FE, 64'd0, rd, er);
        total_cnt++;
        if (rd !== 64'd0 || er !== 1'b1) $display("[TB] FAIL range_word_load: got %h err=%b expected 0/1", rd, er);
        else pass_cnt++;
        run_txn(1'b1, 2'b10, 32'h3FE, 64'h1122_3344, rd, er);
        total_cnt++;
        if (rd !== 64'd0 || er !== 1'b1) $display("[TB] FAIL range_word_store: got %h err=%b expected 0/1", rd, er);
        else pass_cnt++;
        run_txn(1'b0, 2'b01, 32'h3FE, 64'd0, rd, er);
        total_cnt++;
        if (rd !== 64'hA55A || er !== 1'b0) $display("[TB] FAIL range_bytes_kept: got %h err=%b expected a55a/0", rd, er);
        else pass_cnt++;
        run_txn(1'b0, 2'b00, 32'h3FF, 64'd0, rd, er);
        total_cnt++;
        if (rd !== 64'h5A || er !== 1'b0) $display("[TB] FAIL range_last_byte: got %h err=%b expected 5a/0", rd, er);
        else pass_cnt++;
    endtask

    task automatic test_misaligned();
        logic [63:0] exp_half;
        logic        exp_err;
        logic [63:0] exp_b21;
        logic [63:0] exp_b22;
`ifdef DMEM_ALIGN_CHECK_EN
        exp_err  = 1'b1;
        exp_half = 64'd0;
        exp_b21  = 64'h11;
        exp_b22  = 64'h22;
`else
        exp_err  = 1'b0;
        exp_half = 64'hBEEF;
        exp_b21  = 64'hBE;
        exp_b22  = 64'hEF;
`endif
        run_txn(1'b1, 2'b00, 32'h21, 64'h11, rd, er);
        run_txn(1'b1, 2'b00, 32'h22, 64'h22, rd, er);
        run_txn(1'b1, 2'b01, 32'h21, 64'hBEEF, rd, er);
        total_cnt++;
        if (er !== exp_err || rd !== 64'd0) $display("[TB] FAIL mis_store: got err=%b rdata=%h expected %b/0", er, rd, exp_err);
        else pass_cnt++;
        run_txn(1'b0, 2'b01, 32'h21, 64'd0, rd, er);
        total_cnt++;
        if (er !== exp_err || rd !== exp_half) $display("[TB] FAIL mis_load: got err=%b rdata=%h expected %b/%h", er, rd, exp_err, exp_half);
        else pass_cnt++;
        run_txn(1'b0, 2'b00, 32'h21, 64'd0, rd, er);
        total_cnt++;
        if (rd !== exp_b21) $display("[TB] FAIL mis_byte_21: got %h expected %h", rd, exp_b21);
        else pass_cnt++;
        run_txn(1'b0, 2'b00, 32'h22, 64'd0, rd, er);
        total_cnt++;
        if (rd !== exp_b22) $display("[TB] FAIL mis_byte_22: got %h expected %h", rd, exp_b22);
        else pass_cnt++;
    endtask

    task automatic test_reset_inflight();
        run_txn(1'b1, 2'b00, 32'h40, 64'h5C, rd, er);
        @(negedge clock);
        req_valid = 1'b1;
        req_write = 1'b1;
        req_size  = 2'b00;
        req_addr  = 32'h40;
        req_wdata = 64'hFF;
        @(posedge clock);
        #1;
        req_valid = 1'b0;
        @(negedge clock);
        reset = 1'b1;
        #1;
        total_cnt++;
        if (rsp_valid !== 1'b0 || rsp_err !== 1'b0)
            $display("[TB] FAIL inflight_reset_out: got valid=%b err=%b expected 0/0", rsp_valid, rsp_err);
        else pass_cnt++;
        @(posedge clock);
        @(negedge clock);
        reset = 1'b0;
        #1;
        total_cnt++;
        if (req_ready !== 1'b1) $display("[TB] FAIL inflight_ready: got %b expected 1", req_ready);
        else pass_cnt++;
        run_txn(1'b0, 2'b00, 32'h40, 64'd0, rd, er);
        total_cnt++;
        if (rd !== 64'h5C || er !== 1'b0) $display("[TB] FAIL inflight_discard: got %h err=%b expected 5c/0", rd, er);
        else pass_cnt++;
    endtask

    initial begin
        test_reset();
        test_endian();
        test_latency();
        test_range();
        test_misaligned();
        test_reset_inflight();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
